// File: rtl/spi_frame_rx.sv
// Oversampled SPI mode-0 slave receiver: synchronizes SCK/SSEL/DATA_IN, shifts DATA_W bits MSB first,
// validates the frame on SSEL release. Optional watchdog enabled by defining SPI_RX_TIMEOUT_EN.
module spi_frame_rx #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
`ifdef SPI_RX_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              SCK,
    input  logic              SSEL,
    input  logic              DATA_IN,
    output logic [DATA_W-1:0] rx_out,
    output logic              rdy,
    output logic              frame_err,
    output logic [7:0]        err_cnt,
    output logic              busy,
    output logic              link_lost
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Element 0 of each chain is the raw pin; element SYNC_STAGES is the synchronized copy.
    logic [SYNC_STAGES:0] sck_chain;
    logic [SYNC_STAGES:0] ssel_chain;
    logic [SYNC_STAGES:0] data_chain;

    assign sck_chain[0]  = SCK;
    assign ssel_chain[0] = SSEL;
    assign data_chain[0] = DATA_IN;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sck_chain[gi+1]  <= 1'b0;
                    ssel_chain[gi+1] <= 1'b1;
                    data_chain[gi+1] <= 1'b0;
                end else begin
                    sck_chain[gi+1]  <= sck_chain[gi];
                    ssel_chain[gi+1] <= ssel_chain[gi];
                    data_chain[gi+1] <= data_chain[gi];
                end
            end
        end
    endgenerate

    logic sck_sync;
    logic ssel_sync;
    logic data_sync;
    logic sck_d_reg;
    logic ssel_d_reg;

    assign sck_sync  = sck_chain[SYNC_STAGES];
    assign ssel_sync = ssel_chain[SYNC_STAGES];
    assign data_sync = data_chain[SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_d_reg  <= 1'b0;
            ssel_d_reg <= 1'b1;
        end else begin
            sck_d_reg  <= sck_sync;
            ssel_d_reg <= ssel_sync;
        end
    end

    logic sck_rise;
    logic ssel_fall;
    logic ssel_rise;

    assign sck_rise  = sck_sync & ~sck_d_reg;
    assign ssel_fall = ~ssel_sync & ssel_d_reg;
    assign ssel_rise = ssel_sync & ~ssel_d_reg;

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              overrun_reg;
    logic [DATA_W-1:0] rx_out_reg;
    logic              rdy_reg;
    logic              frame_err_reg;
    logic [7:0]        err_cnt_reg;
    logic              busy_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            overrun_reg   <= 1'b0;
            rx_out_reg    <= '0;
            rdy_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
            err_cnt_reg   <= 8'd0;
            busy_reg      <= 1'b0;
        end else begin
            rdy_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (en && ssel_fall) begin
                        state_reg   <= ST_SHIFT;
                        bit_cnt_reg <= '0;
                        overrun_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!en) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (ssel_rise) begin
                        // A coincident SCK edge is dropped: the frame is already over.
                        state_reg <= ST_CHECK;
                        busy_reg  <= 1'b0;
                    end else if (sck_rise) begin
                        if (bit_cnt_reg == FULL_CNT) begin
                            overrun_reg <= 1'b1;
                        end else begin
                            shift_reg   <= {shift_reg[DATA_W-2:0], data_sync};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    state_reg <= ST_IDLE;
                    if (en) begin
                        if ((bit_cnt_reg == FULL_CNT) && !overrun_reg) begin
                            rx_out_reg <= shift_reg;
                            rdy_reg    <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                            if (err_cnt_reg != 8'hFF) begin
                                err_cnt_reg <= err_cnt_reg + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_out    = rx_out_reg;
    assign rdy       = rdy_reg;
    assign frame_err = frame_err_reg;
    assign err_cnt   = err_cnt_reg;
    assign busy      = busy_reg;

`ifdef SPI_RX_TIMEOUT_EN
    logic [23:0] wd_cnt_reg;
    logic        link_lost_reg;

    // Counter parks at TIMEOUT_CYCLES; link_lost is sticky until the next good word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_reg    <= 24'd0;
            link_lost_reg <= 1'b0;
        end else if (!en) begin
            wd_cnt_reg <= 24'd0;
        end else if (rdy_reg) begin
            wd_cnt_reg    <= 24'd0;
            link_lost_reg <= 1'b0;
        end else begin
            if (wd_cnt_reg != TIMEOUT_CYCLES) begin
                wd_cnt_reg <= wd_cnt_reg + 24'd1;
            end
            if (wd_cnt_reg >= (TIMEOUT_CYCLES - 24'd1)) begin
                link_lost_reg <= 1'b1;
            end
        end
    end

    assign link_lost = link_lost_reg;
`else
    assign link_lost = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed testbench for spi_frame_rx: good/short/overrun frames, error saturation, abort paths, watchdog.
module tb_spi_frame_rx;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        SCK;
    logic        SSEL;
    logic        DATA_IN;
    logic [31:0] rx_out;
    logic        rdy;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;
    logic        link_lost;

    int n_cmp;
    int n_bad;
    int rdy_hi_cnt;
    int ferr_hi_cnt;
    int both_hi_cnt;
    int link_hi_cnt;

    spi_frame_rx #(
        .DATA_W(32),
        .SYNC_STAGES(2)
`ifdef SPI_RX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(24'd100)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .SCK(SCK),
        .SSEL(SSEL),
        .DATA_IN(DATA_IN),
        .rx_out(rx_out),
        .rdy(rdy),
        .frame_err(frame_err),
        .err_cnt(err_cnt),
        .busy(busy),
        .link_lost(link_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse activity is tallied on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rdy) rdy_hi_cnt++;
            if (frame_err) ferr_hi_cnt++;
            if (rdy && frame_err) both_hi_cnt++;
            if (link_lost) link_hi_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sel_low();
        SSEL = 1'b0;
        wait_clk(4);
    endtask

    task automatic clock_bit(input logic b);
        DATA_IN = b;
        wait_clk(3);
        SCK = 1'b1;
        wait_clk(3);
        SCK = 1'b0;
    endtask

    task automatic sel_high();
        wait_clk(3);
        SSEL = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits);
        sel_low();
        for (int i = 0; i < nbits; i++) begin
            clock_bit((i < 32) ? data[31-i] : 1'b0);
        end
        sel_high();
        $display("frame data=%08h bits=%0d -> rx_out=%08h err_cnt=%0d", data, nbits, rx_out, err_cnt);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en = 1'b1;
        SCK = 1'b0;
        SSEL = 1'b1;
        DATA_IN = 1'b0;
        wait_clk(3);
        n_cmp++;
        if (rx_out !== 32'h0) begin n_bad++; $display("FAIL reset_rx_out got=%08h exp=00000000", rx_out); end
        n_cmp++;
        if ({rdy, frame_err, busy, link_lost} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=0000", {rdy, frame_err, busy, link_lost});
        end
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        reset_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_good_frame();
        int r0, f0;
        r0 = rdy_hi_cnt; f0 = ferr_hi_cnt;
        send_frame(32'h3F66_6666, 32);
        n_cmp++;
        if (rx_out !== 32'h3F66_6666) begin n_bad++; $display("FAIL good_rx_out got=%08h exp=3f666666", rx_out); end
        n_cmp++;
        if (rdy_hi_cnt - r0 !== 1) begin n_bad++; $display("FAIL good_rdy_cycles got=%0d exp=1", rdy_hi_cnt - r0); end
        n_cmp++;
        if (ferr_hi_cnt - f0 !== 0) begin n_bad++; $display("FAIL good_frame_err got=%0d exp=0", ferr_hi_cnt - f0); end
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL good_err_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_short_frame();
        int r0, f0;
        r0 = rdy_hi_cnt; f0 = ferr_hi_cnt;
        send_frame(32'hFFFF_FFFF, 31);
        n_cmp++;
        if (ferr_hi_cnt - f0 !== 1) begin n_bad++; $display("FAIL short_frame_err got=%0d exp=1", ferr_hi_cnt - f0); end
        n_cmp++;
        if (rdy_hi_cnt - r0 !== 0) begin n_bad++; $display("FAIL short_rdy got=%0d exp=0", rdy_hi_cnt - r0); end
        n_cmp++;
        if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL short_err_cnt got=%0d exp=1", err_cnt); end
        n_cmp++;
        if (rx_out !== 32'h3F66_6666) begin n_bad++; $display("FAIL short_rx_hold got=%08h exp=3f666666", rx_out); end
        r0 = rdy_hi_cnt;
        send_frame(32'h1234_5678, 32);
        n_cmp++;
        if (rx_out !== 32'h1234_5678) begin n_bad++; $display("FAIL short_next_rx_out got=%08h exp=12345678", rx_out); end
        n_cmp++;
        if (rdy_hi_cnt - r0 !== 1) begin n_bad++; $display("FAIL short_next_rdy got=%0d exp=1", rdy_hi_cnt - r0); end
    endtask

    task automatic test_overrun();
        int r0, f0;
        r0 = rdy_hi_cnt; f0 = ferr_hi_cnt;
        send_frame(32'hA5A5_A5A5, 33);
        n_cmp++;
        if (ferr_hi_cnt - f0 !== 1) begin n_bad++; $display("FAIL overrun_frame_err got=%0d exp=1", ferr_hi_cnt - f0); end
        n_cmp++;
        if (rdy_hi_cnt - r0 !== 0) begin n_bad++; $display("FAIL overrun_rdy got=%0d exp=0", rdy_hi_cnt - r0); end
        n_cmp++;
        if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL overrun_err_cnt got=%0d exp=2", err_cnt); end
        n_cmp++;
        if (rx_out !== 32'h1234_5678) begin n_bad++; $display("FAIL overrun_rx_hold got=%08h exp=12345678", rx_out); end
    endtask

    task automatic test_back_to_back();
        int r0, f0;
        f0 = ferr_hi_cnt;
        for (int k = 0; k < 300; k++) begin
            send_frame(32'hC000_0000, 2);
        end
        n_cmp++;
        if (ferr_hi_cnt - f0 !== 300) begin n_bad++; $display("FAIL b2b_frame_err got=%0d exp=300", ferr_hi_cnt - f0); end
        n_cmp++;
        if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL b2b_err_sat got=%0d exp=255", err_cnt); end
        r0 = rdy_hi_cnt;
        send_frame(32'hDEAD_BEEF, 32);
        n_cmp++;
        if (rx_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL b2b_rx_out got=%08h exp=deadbeef", rx_out); end
        n_cmp++;
        if (rdy_hi_cnt - r0 !== 1) begin n_bad++; $display("FAIL b2b_rdy got=%0d exp=1", rdy_hi_cnt - r0); end
        n_cmp++;
        if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL b2b_err_hold got=%0d exp=255", err_cnt); end
        n_cmp++;
        if (both_hi_cnt !== 0) begin n_bad++; $display("FAIL rdy_and_err_overlap got=%0d exp=0", both_hi_cnt); end
    endtask

    task automatic test_abort_en();
        int r0, f0;
        r0 = rdy_hi_cnt; f0 = ferr_hi_cnt;
        sel_low();
        for (int i = 0; i < 16; i++) clock_bit(i[0]);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_mid got=%b exp=1", busy); end
        en = 1'b0;
        wait_clk(4);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_idle got=%b exp=0", busy); end
        for (int i = 16; i < 32; i++) clock_bit(i[0]);
        en = 1'b1;
        sel_high();
        $display("frame aborted by en after 16 bits -> rx_out=%08h err_cnt=%0d", rx_out, err_cnt);
        n_cmp++;
        if ((rdy_hi_cnt - r0) + (ferr_hi_cnt - f0) !== 0) begin
            n_bad++; $display("FAIL abort_en_pulses got=%0d exp=0", (rdy_hi_cnt - r0) + (ferr_hi_cnt - f0));
        end
        n_cmp++;
        if (rx_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL abort_en_rx_hold got=%08h exp=deadbeef", rx_out); end
    endtask

    task automatic test_abort_reset();
        int r0;
        sel_low();
        for (int i = 0; i < 10; i++) clock_bit(1'b1);
        reset_n = 1'b0;
        SSEL = 1'b1;
        SCK = 1'b0;
        #1;
        n_cmp++;
        if ({rx_out, err_cnt} !== 40'h0) begin n_bad++; $display("FAIL rst_mid_data got=%08h/%0d exp=0/0", rx_out, err_cnt); end
        n_cmp++;
        if ({rdy, frame_err, busy, link_lost} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_mid_flags got=%b exp=0000", {rdy, frame_err, busy, link_lost});
        end
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(6);
        r0 = rdy_hi_cnt;
        send_frame(32'h0000_0001, 32);
        n_cmp++;
        if (rx_out !== 32'h0000_0001) begin n_bad++; $display("FAIL rst_next_rx_out got=%08h exp=00000001", rx_out); end
        n_cmp++;
        if (rdy_hi_cnt - r0 !== 1) begin n_bad++; $display("FAIL rst_next_rdy got=%0d exp=1", rdy_hi_cnt - r0); end
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_next_err_cnt got=%0d exp=0", err_cnt); end
    endtask

`ifdef SPI_RX_TIMEOUT_EN
    task automatic test_timeout();
        int r0;
        bit seen;
        sel_low();
        for (int i = 0; i < 32; i++) clock_bit(i[1]);
        wait_clk(3);
        SSEL = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            wait_clk(1);
            if (rdy) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL timeout_rdy_wait got=0 exp=1"); end
        wait_clk(99);
        n_cmp++;
        if (link_lost !== 1'b0) begin n_bad++; $display("FAIL timeout_early got=%b exp=0", link_lost); end
        wait_clk(3);
        n_cmp++;
        if (link_lost !== 1'b1) begin n_bad++; $display("FAIL timeout_set got=%b exp=1", link_lost); end
        r0 = rdy_hi_cnt;
        send_frame(32'h0BAD_F00D, 32);
        n_cmp++;
        if (link_lost !== 1'b0) begin n_bad++; $display("FAIL timeout_clear got=%b exp=0", link_lost); end
        n_cmp++;
        if (rdy_hi_cnt - r0 !== 1) begin n_bad++; $display("FAIL timeout_rdy got=%0d exp=1", rdy_hi_cnt - r0); end
    endtask
`else
    task automatic test_no_timeout();
        wait_clk(200);
        n_cmp++;
        if (link_hi_cnt !== 0) begin n_bad++; $display("FAIL link_lost_tied got=%0d exp=0", link_hi_cnt); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rdy_hi_cnt = 0;
        ferr_hi_cnt = 0;
        both_hi_cnt = 0;
        link_hi_cnt = 0;
        test_reset();
        test_good_frame();
        test_short_frame();
        test_overrun();
        test_back_to_back();
        test_abort_en();
        test_abort_reset();
`ifdef SPI_RX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
